radiometer_dicke_integrator: RTL and testbench

//  Parametrised successor to the single-channel switch/ADC demod path: generates the Dicke switching

---
 rtl/radiometer_dicke_integrator_if.sv | 17 +
 rtl/radiometer_dicke_integrator.sv | 157 +++++++++++++++
 tb/tb_radiometer_dicke_integrator.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/radiometer_dicke_integrator_if.sv
// Result stream from the Dicke integrator to the UART path: one signed
// antenna-minus-reference word per channel, with a valid/ready handshake.
interface radiometer_dicke_integrator_if #(
  parameter int NCH   = 2,
  parameter int ACC_W = 40
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                    out_valid;
  logic                    out_ready;
  logic [CHW-1:0]          out_chan;
  logic signed [ACC_W:0]   out_data;
  logic                    out_last;

  modport master (output out_valid, out_chan, out_data, out_last, input out_ready);
  modport slave  (input out_valid, out_chan, out_data, out_last, output out_ready);
endinterface

// File: rtl/radiometer_dicke_integrator.sv
// Dicke switch generator with post-edge blanking, per-channel antenna/reference
// integration over NPER switch periods, and a per-frame result dump stream.
module radiometer_dicke_integrator #(
  parameter int NCH     = 2,
  parameter int SAMP_W  = 12,
  parameter int SW_HALF = 50000,
  parameter int BLANK   = 1000,
  parameter int NPER    = 100,
  parameter int ACC_W   = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    sample_valid,
  input  logic [NCH*SAMP_W-1:0]   sample_data,
  output logic                    switch_pwm,
  output logic                    overrun,
  radiometer_dicke_integrator_if.master out_if
);
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PH_W  = (SW_HALF > 1) ? $clog2(SW_HALF) : 1;
  localparam int PER_W = (NPER > 1) ? $clog2(NPER) : 1;

  localparam logic [PH_W-1:0]  BLANK_PH = PH_W'(BLANK);
  localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(SW_HALF - 1);
  localparam logic [PER_W-1:0] LAST_PER = PER_W'(NPER - 1);
  localparam logic [CHW-1:0]   LAST_CH  = CHW'(NCH - 1);

  generate
    if (ACC_W < SAMP_W + $clog2(SW_HALF * NPER)) begin : g_acc_w_check
      $error("ACC_W too small: accumulators could wrap within one frame");
    end
  endgenerate

  typedef enum logic { IDLE,  RUN  } run_state_t;
  typedef enum logic { DIDLE, DUMP } dump_state_t;

  run_state_t              run_state;
  dump_state_t             dump_state;
  logic [PH_W-1:0]         phase;
  logic [PER_W-1:0]        period;
  logic [ACC_W-1:0]        ant_acc  [NCH];
  logic [ACC_W-1:0]        ref_acc  [NCH];
  logic [ACC_W-1:0]        ant_nxt  [NCH];
  logic [ACC_W-1:0]        ref_nxt  [NCH];
  logic signed [ACC_W:0]   diff_nxt [NCH];
  logic signed [ACC_W:0]   snap     [NCH];

  logic            running;
  logic            accept;
  logic            phase_wrap;
  logic            frame_end;
  logic            xfer;
  logic [CHW-1:0]  next_chan;

  // The frame-closing sample is folded in before the difference is taken, so
  // the snapshot sees exactly what the accumulators would have held.
  always_comb begin
    running    = (run_state == RUN) && enable;
    accept     = running && sample_valid && (phase >= BLANK_PH);
    phase_wrap = running && (phase == LAST_PH);
    frame_end  = phase_wrap && !switch_pwm && (period == LAST_PER);
    xfer       = out_if.out_valid && out_if.out_ready;
    next_chan  = out_if.out_chan + 1'b1;
    for (int c = 0; c < NCH; c++) begin
      ant_nxt[c]  = ant_acc[c] + ((accept && switch_pwm)  ? ACC_W'(sample_data[c*SAMP_W +: SAMP_W]) : '0);
      ref_nxt[c]  = ref_acc[c] + ((accept && !switch_pwm) ? ACC_W'(sample_data[c*SAMP_W +: SAMP_W]) : '0);
      diff_nxt[c] = $signed({1'b0, ant_nxt[c]}) - $signed({1'b0, ref_nxt[c]});
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_state  <= IDLE;
      phase      <= '0;
      period     <= '0;
      switch_pwm <= 1'b0;
      // NOTE: the accumulator arrays are reset explicitly; a reset mid-frame
      // must not leak partial sums into the next frame.
      for (int c = 0; c < NCH; c++) begin
        ant_acc[c] <= '0;
        ref_acc[c] <= '0;
      end
    end else begin
      case (run_state)
        IDLE: begin
          if (enable) begin
            run_state  <= RUN;
            phase      <= '0;
            period     <= '0;
            switch_pwm <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            run_state  <= IDLE;
            phase      <= '0;
            period     <= '0;
            switch_pwm <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
              ant_acc[c] <= '0;
              ref_acc[c] <= '0;
            end
          end else begin
            phase <= phase_wrap ? '0 : phase + 1'b1;
            if (phase_wrap) begin
              switch_pwm <= !switch_pwm;
              if (!switch_pwm)
                period <= (period == LAST_PER) ? '0 : period + 1'b1;
            end
            for (int c = 0; c < NCH; c++) begin
              ant_acc[c] <= frame_end ? '0 : ant_nxt[c];
              ref_acc[c] <= frame_end ? '0 : ref_nxt[c];
            end
          end
        end
        default: run_state <= IDLE;
      endcase
    end
  end

  // A new frame is only taken when the dumper is idle or is handing off its
  // last word on this very edge; otherwise it is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dump_state       <= DIDLE;
      out_if.out_valid <= 1'b0;
      out_if.out_chan  <= '0;
      out_if.out_data  <= '0;
      out_if.out_last  <= 1'b0;
      overrun          <= 1'b0;
      for (int c = 0; c < NCH; c++) snap[c] <= '0;
    end else if (frame_end && ((dump_state == DIDLE) || (xfer && out_if.out_last))) begin
      snap             <= diff_nxt;
      dump_state       <= DUMP;
      out_if.out_valid <= 1'b1;
      out_if.out_chan  <= '0;
      out_if.out_data  <= diff_nxt[0];
      out_if.out_last  <= (NCH == 1);
    end else begin
      if (frame_end) overrun <= 1'b1;
      if (xfer) begin
        if (out_if.out_last) begin
          dump_state       <= DIDLE;
          out_if.out_valid <= 1'b0;
          out_if.out_last  <= 1'b0;
        end else begin
          out_if.out_chan <= next_chan;
          out_if.out_data <= snap[next_chan];
          out_if.out_last <= (next_chan == LAST_CH);
        end
      end
    end
  end
endmodule

// File: tb/tb_radiometer_dicke_integrator.sv
// Self-checking bench: drives directed and random stimulus and compares every
// cycle against a frame-level model built from cycle count arithmetic.
module tb_radiometer_dicke_integrator;
  localparam int NCH     = 2;
  localparam int SAMP_W  = 12;
  localparam int SW_HALF = 8;
  localparam int BLANK   = 2;
  localparam int NPER    = 2;
  localparam int ACC_W   = 20;
  localparam int FRAME   = 2 * SW_HALF * NPER;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  enable;
  logic                  sample_valid;
  logic [NCH*SAMP_W-1:0] sample_data;
  logic                  switch_pwm;
  logic                  overrun;

  radiometer_dicke_integrator_if #(.NCH(NCH), .ACC_W(ACC_W)) out_if ();

  radiometer_dicke_integrator #(
    .NCH(NCH), .SAMP_W(SAMP_W), .SW_HALF(SW_HALF),
    .BLANK(BLANK), .NPER(NPER), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .switch_pwm(switch_pwm), .overrun(overrun),
    .out_if(out_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     chan;
    longint data;
    bit     last;
  } word_t;

  // Reference model: time since RUN entry decides half, phase and frame edges.
  word_t  exp_q[$];
  bit     m_run;
  int     m_k;
  longint m_ant[NCH];
  longint m_ref[NCH];
  bit     m_ovr;
  int     checks   = 0;
  int     failures = 0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NCH*SAMP_W-1:0] pack(input int ch0, input int ch1);
    return {SAMP_W'(ch1), SAMP_W'(ch0)};
  endfunction

  function automatic bit m_pwm();
    return m_run && (((m_k / SW_HALF) % 2) == 0);
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_k   = 0;
    m_ovr = 1'b0;
    exp_q.delete();
    for (int c = 0; c < NCH; c++) begin
      m_ant[c] = 0;
      m_ref[c] = 0;
    end
  endtask

  task automatic model_step(input bit en, input bit sv, input logic [NCH*SAMP_W-1:0] d, input bit rdy);
    bit    fe;
    bit    xf;
    word_t w;
    fe = 1'b0;
    xf = (exp_q.size() > 0) && rdy;
    if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_k   = 0;
      end
    end else if (!en) begin
      m_run = 1'b0;
      m_k   = 0;
      for (int c = 0; c < NCH; c++) begin
        m_ant[c] = 0;
        m_ref[c] = 0;
      end
    end else begin
      if (sv && (m_k % SW_HALF) >= BLANK) begin
        for (int c = 0; c < NCH; c++) begin
          if (((m_k / SW_HALF) % 2) == 0) m_ant[c] += longint'(d[c*SAMP_W +: SAMP_W]);
          else                             m_ref[c] += longint'(d[c*SAMP_W +: SAMP_W]);
        end
      end
      fe  = ((m_k + 1) % FRAME) == 0;
      m_k = m_k + 1;
    end
    if (xf) void'(exp_q.pop_front());
    if (fe) begin
      if (exp_q.size() == 0) begin
        for (int c = 0; c < NCH; c++) begin
          w.chan = c;
          w.data = m_ant[c] - m_ref[c];
          w.last = (c == NCH - 1);
          exp_q.push_back(w);
        end
      end else begin
        m_ovr = 1'b1;
      end
      for (int c = 0; c < NCH; c++) begin
        m_ant[c] = 0;
        m_ref[c] = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    check("switch_pwm", switch_pwm, m_pwm());
    check("overrun", overrun, m_ovr);
    check("out_valid", out_if.out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check("out_chan", out_if.out_chan, exp_q[0].chan);
      check("out_data", $signed(out_if.out_data), exp_q[0].data);
      check("out_last", out_if.out_last, exp_q[0].last);
    end
  endtask

  // Called on a negedge: check current outputs, drive next inputs, advance one cycle.
  task automatic cycle(input bit en, input bit sv, input logic [NCH*SAMP_W-1:0] d, input bit rdy);
    compare_outputs();
    enable           = en;
    sample_valid     = sv;
    sample_data      = d;
    out_if.out_ready = rdy;
    model_step(en, sv, d, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    enable           = 1'b0;
    sample_valid     = 1'b0;
    sample_data      = '0;
    out_if.out_ready = 1'b0;
    #1;
    check("rst_switch_pwm", switch_pwm, 0);
    check("rst_out_valid", out_if.out_valid, 0);
    check("rst_out_chan", out_if.out_chan, 0);
    check("rst_out_data", $signed(out_if.out_data), 0);
    check("rst_out_last", out_if.out_last, 0);
    check("rst_overrun", overrun, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit seen;
    int seen_i;
    bit seen_ch1;
    bit ant;
    rst_n = 1'b0;
    @(negedge clk);

    // 1: constant inputs, equal on both halves -> zero differences.
    do_reset();
    for (int i = 0; i < 80; i++) cycle(1'b1, 1'b1, pack(10, 7), 1'b1);

    // 2: half-dependent inputs -> ch0 = +72, ch1 = -1200; first valid after frame end.
    do_reset();
    seen = 1'b0;
    seen_ch1 = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (!seen && out_if.out_valid) begin
        seen = 1'b1;
        check("t2_first_valid_cycle", i, 33);
        check("t2_chan0_value", $signed(out_if.out_data), 72);
      end
      if (!seen_ch1 && out_if.out_valid && out_if.out_chan == 1'b1) begin
        seen_ch1 = 1'b1;
        check("t2_chan1_value", $signed(out_if.out_data), -1200);
      end
      ant = m_pwm();
      cycle(1'b1, 1'b1, ant ? pack(10, 0) : pack(4, 100), 1'b1);
    end
    check("t2_saw_words", seen && seen_ch1, 1);

    // 3: samples only inside the blanking window -> all results zero.
    do_reset();
    for (int i = 0; i < 100; i++)
      cycle(1'b1, (m_k % SW_HALF) < BLANK, pack($urandom_range(0, 4095), $urandom_range(0, 4095)), 1'b1);

    // 4: stalled consumer -> first word held, second frame dropped, overrun set.
    do_reset();
    seen = 1'b0;
    seen_i = 0;
    for (int i = 0; i < 140; i++) begin
      if (!seen && out_if.out_valid) begin
        seen = 1'b1;
        seen_i = i;
      end
      cycle(1'b1, 1'b1, pack($urandom_range(0, 4095), $urandom_range(0, 4095)),
            !seen || (i >= seen_i + 40));
    end
    check("t4_overrun_sticky", overrun, 1);

    // 5: enable dropped mid-frame, then restarted.
    do_reset();
    for (int i = 0; i < 90; i++) begin
      if (i == 29) check("t5_idle_pwm", switch_pwm, 0);
      if (i == 31) check("t5_restart_pwm", switch_pwm, 1);
      cycle(!(i >= 20 && i < 30), 1'b1, pack($urandom_range(0, 4095), $urandom_range(0, 4095)), 1'b1);
    end

    // Random traffic with occasional enable drops and back-pressure.
    do_reset();
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0,
            pack($urandom_range(0, 4095), $urandom_range(0, 4095)), $urandom_range(0, 9) < 7);

    // Reset asserted while a dump is pending.
    for (int i = 0; i < 200 && exp_q.size() == 0; i++)
      cycle(1'b1, 1'b1, pack($urandom_range(0, 4095), $urandom_range(0, 4095)), 1'b0);
    check("reach_dump", out_if.out_valid, 1);
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
